// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: condition codes, NZCV bit positions and flag-write masks.
// The flag merge helper is shared by the control pipeline.
package arm_pipe_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'ha;
   localparam logic [3:0] COND_LT = 4'hb;
   localparam logic [3:0] COND_GT = 4'hc;
   localparam logic [3:0] COND_LE = 4'hd;
   localparam logic [3:0] COND_AL = 4'he;
   localparam logic [3:0] COND_NV = 4'hf;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [1:0] FLAGW_NZ = 2'b10;
   localparam logic [1:0] FLAGW_CV = 2'b01;

   // Control bits carried per stage; the payload travels separately since its width is a parameter.
   typedef struct packed {
      logic       valid;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       branch;
      logic [1:0] flagw;
      logic [3:0] cond;
   } ctrl_t;

   function automatic logic [3:0] merge_flags(input logic [3:0] cur, input logic [3:0] alu,
                                              input logic [1:0] flagw);
      logic [3:0] res;
      res = cur;
      if ((flagw & FLAGW_NZ) != 2'b00) begin
         res[FLAG_N] = alu[FLAG_N];
         res[FLAG_Z] = alu[FLAG_Z];
      end
      if ((flagw & FLAGW_CV) != 2'b00) begin
         res[FLAG_C] = alu[FLAG_C];
         res[FLAG_V] = alu[FLAG_V];
      end
      return res;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check: condition field plus NZCV yields pass.
module cond_eval
   import arm_pipe_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n    = nzcv[FLAG_N];
      z    = nzcv[FLAG_Z];
      c    = nzcv[FLAG_C];
      v    = nzcv[FLAG_V];
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_pipe_ctrl.sv
// Control-signal pipeline from decode through NSTAGES registered stages with condition gating,
// NZCV flag register, per-stage stall/flush and bubble insertion.
module cond_pipe_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int unsigned NSTAGES = 3,
   parameter int unsigned PAY_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_d,
   input  logic                     pcs_d,
   input  logic                     regw_d,
   input  logic                     memw_d,
   input  logic                     branch_d,
   input  logic [1:0]               flagw_d,
   input  logic [3:0]               cond_d,
   input  logic [PAY_W-1:0]         payload_d,
   input  logic [3:0]               alu_flags,
   input  logic [NSTAGES-1:0]       stall,
   input  logic [NSTAGES-1:0]       flush,
   output logic                     stall_d_o,
   output logic                     cond_ex_e,
   output logic                     branch_taken_e,
   output logic [3:0]               flags,
   output logic [NSTAGES-1:0]       valid_q,
   output logic [NSTAGES-1:0]       pcs_q,
   output logic [NSTAGES-1:0]       regw_q,
   output logic [NSTAGES-1:0]       memw_q,
   output logic [NSTAGES*PAY_W-1:0] payload_q
);

   if (NSTAGES < 2) begin : g_bad_nstages
      $error("cond_pipe_ctrl: NSTAGES must be at least 2");
   end

   logic [NSTAGES-1:0] se;
   ctrl_t              ctrl_s [NSTAGES];
   logic [PAY_W-1:0]   pay_s  [NSTAGES];
   ctrl_t              dec_ctrl;
   logic               cond_pass;
   logic               flag_we;

   // A stall at any later stage also holds every earlier stage.
   always_comb begin
      se[NSTAGES-1] = stall[NSTAGES-1];
      for (int k = NSTAGES - 2; k >= 0; k--) begin
         se[k] = stall[k] | se[k+1];
      end
   end

   always_comb begin
      dec_ctrl = '0;
      if (valid_d) begin
         dec_ctrl.valid  = 1'b1;
         dec_ctrl.pcs    = pcs_d;
         dec_ctrl.regw   = regw_d;
         dec_ctrl.memw   = memw_d;
         dec_ctrl.branch = branch_d;
         dec_ctrl.flagw  = flagw_d;
         dec_ctrl.cond   = cond_d;
      end
   end

   cond_eval u_cond_eval (
      .cond (ctrl_s[0].cond),
      .nzcv (flags),
      .pass (cond_pass)
   );

   assign cond_ex_e      = ctrl_s[0].valid & cond_pass;
   assign branch_taken_e = ctrl_s[0].branch & cond_ex_e;
   assign stall_d_o      = se[0] & reset;

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      ctrl_t            ctrl_q;
      logic [PAY_W-1:0] pay_q;
      ctrl_t            src_ctrl;
      logic [PAY_W-1:0] src_pay;
      logic             bubble;

      if (k == 0) begin : g_src_dec
         assign src_ctrl = dec_ctrl;
         assign src_pay  = valid_d ? payload_d : '0;
         assign bubble   = 1'b0;
      end else if (k == 1) begin : g_src_gated
         // Only state-changing bits are suppressed by a failed condition.
         always_comb begin
            src_ctrl      = ctrl_s[0];
            src_ctrl.pcs  = ctrl_s[0].pcs & cond_ex_e;
            src_ctrl.regw = ctrl_s[0].regw & cond_ex_e;
            src_ctrl.memw = ctrl_s[0].memw & cond_ex_e;
         end
         assign src_pay = pay_s[0];
         assign bubble  = se[0];
      end else begin : g_src_copy
         assign src_ctrl = ctrl_s[k-1];
         assign src_pay  = pay_s[k-1];
         assign bubble   = se[k-1];
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            ctrl_q <= '0;
            pay_q  <= '0;
         end else if (flush[k]) begin
            ctrl_q <= '0;
            pay_q  <= '0;
         end else if (se[k]) begin
            ctrl_q <= ctrl_q;
            pay_q  <= pay_q;
         end else if (bubble) begin
            ctrl_q <= '0;
            pay_q  <= '0;
         end else begin
            ctrl_q <= src_ctrl;
            pay_q  <= src_pay;
         end
      end

      assign ctrl_s[k]                    = ctrl_q;
      assign pay_s[k]                     = pay_q;
      assign valid_q[k]                   = ctrl_q.valid;
      assign pcs_q[k]                     = ctrl_q.pcs;
      assign regw_q[k]                    = ctrl_q.regw;
      assign memw_q[k]                    = ctrl_q.memw;
      assign payload_q[k*PAY_W +: PAY_W] = pay_q;
   end

   // Flags commit only on the edge the instruction leaves stage 1 for stage 2, so a held
   // instruction writes exactly once.
   assign flag_we = ~flush[1] & ~se[0] & cond_ex_e & (ctrl_s[0].flagw != 2'b00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags <= 4'b0000;
      end else if (flag_we) begin
         flags <= merge_flags(flags, alu_flags, ctrl_s[0].flagw);
      end
   end

endmodule

// File: tb/tb_cond_pipe_ctrl.sv
// Self-checking bench for cond_pipe_ctrl: directed scenarios plus randomized traffic against
// an instruction-level reference model.
module tb_cond_pipe_ctrl;

   localparam int NS = 3;
   localparam int PW = 8;

   logic            clk;
   logic            reset;
   logic            valid_d, pcs_d, regw_d, memw_d, branch_d;
   logic [1:0]      flagw_d;
   logic [3:0]      cond_d;
   logic [PW-1:0]   payload_d;
   logic [3:0]      alu_flags;
   logic [NS-1:0]   stall, flush;
   logic            stall_d_o, cond_ex_e, branch_taken_e;
   logic [3:0]      flags;
   logic [NS-1:0]   valid_q, pcs_q, regw_q, memw_q;
   logic [NS*PW-1:0] payload_q;

   cond_pipe_ctrl #(.NSTAGES(NS), .PAY_W(PW)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_d        (valid_d),
      .pcs_d          (pcs_d),
      .regw_d         (regw_d),
      .memw_d         (memw_d),
      .branch_d       (branch_d),
      .flagw_d        (flagw_d),
      .cond_d         (cond_d),
      .payload_d      (payload_d),
      .alu_flags      (alu_flags),
      .stall          (stall),
      .flush          (flush),
      .stall_d_o      (stall_d_o),
      .cond_ex_e      (cond_ex_e),
      .branch_taken_e (branch_taken_e),
      .flags          (flags),
      .valid_q        (valid_q),
      .pcs_q          (pcs_q),
      .regw_q         (regw_q),
      .memw_q         (memw_q),
      .payload_q      (payload_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       v, pcs, regw, memw, br;
      bit [1:0] fw;
      bit [3:0] cond;
      bit [7:0] pay;
   } ins_t;

   ins_t     m [NS];
   bit [3:0] mflags;
   int       n_checks = 0;
   int       n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Condition table as base predicate per pair, odd codes invert (except NV).
   function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hf) return 1'b0;
      return base ^ c[0];
   endfunction

   function automatic bit se_of(input int k);
      for (int j = k; j < NS; j++) if (stall[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ce();
      return m[0].v && cond_ok(m[0].cond, mflags);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NS; k++) m[k] = '{default: 0};
      mflags = 4'b0;
   endtask

   task automatic model_next();
      ins_t nm [NS];
      bit   ce;
      ce = m_ce();
      for (int k = 0; k < NS; k++) begin
         if (flush[k]) nm[k] = '{default: 0};
         else if (se_of(k)) nm[k] = m[k];
         else if (k == 0) begin
            if (valid_d)
               nm[0] = '{v: 1'b1, pcs: pcs_d, regw: regw_d, memw: memw_d, br: branch_d,
                         fw: flagw_d, cond: cond_d, pay: payload_d};
            else nm[0] = '{default: 0};
         end else if (se_of(k - 1)) nm[k] = '{default: 0};
         else begin
            nm[k] = m[k-1];
            if (k == 1) begin
               nm[k].pcs  = nm[k].pcs && ce;
               nm[k].regw = nm[k].regw && ce;
               nm[k].memw = nm[k].memw && ce;
            end
         end
      end
      if (!flush[1] && !se_of(0) && ce) begin
         if (m[0].fw[1]) mflags[3:2] = alu_flags[3:2];
         if (m[0].fw[0]) mflags[1:0] = alu_flags[1:0];
      end
      m = nm;
   endtask

   task automatic check_comb();
      check("stall_d_o", stall_d_o, se_of(0));
      check("cond_ex_e", cond_ex_e, m_ce());
      check("branch_taken_e", branch_taken_e, m_ce() && m[0].br);
   endtask

   task automatic check_regs();
      logic [NS-1:0]    ev, ep, er, em;
      logic [NS*PW-1:0] epay;
      for (int k = 0; k < NS; k++) begin
         ev[k] = m[k].v; ep[k] = m[k].pcs; er[k] = m[k].regw; em[k] = m[k].memw;
         epay[k*PW +: PW] = m[k].pay;
      end
      check("valid_q", valid_q, ev);
      check("pcs_q", pcs_q, ep);
      check("regw_q", regw_q, er);
      check("memw_q", memw_q, em);
      check("payload_q", payload_q, epay);
      check("flags", flags, mflags);
   endtask

   task automatic check_zero();
      check("rst_stall_d_o", stall_d_o, 0);
      check("rst_cond_ex_e", cond_ex_e, 0);
      check("rst_branch_taken", branch_taken_e, 0);
      check("rst_flags", flags, 0);
      check("rst_valid_q", valid_q, 0);
      check("rst_pcs_q", pcs_q, 0);
      check("rst_regw_q", regw_q, 0);
      check("rst_memw_q", memw_q, 0);
      check("rst_payload_q", payload_q, 0);
   endtask

   // Inputs are set at posedge+1; combinational outputs checked 1 later, registers after the edge.
   task automatic step();
      #1;
      check_comb();
      model_next();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic set_dec(input bit v, input bit p, input bit r, input bit w, input bit b,
                          input bit [1:0] fw, input bit [3:0] c, input bit [7:0] pay);
      valid_d = v; pcs_d = p; regw_d = r; memw_d = w; branch_d = b;
      flagw_d = fw; cond_d = c; payload_d = pay;
   endtask

   task automatic nop();
      set_dec(0, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00);
   endtask

   task automatic rand_inputs(input bit ctl);
      set_dec($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      alu_flags = 4'($urandom_range(0, 15));
      for (int j = 0; j < NS; j++) begin
         stall[j] = ctl ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1);
         flush[j] = ctl ? ($urandom_range(0, 15) == 0) : $urandom_range(0, 1);
      end
   endtask

   task automatic reset_phase(input int cycles);
      #2;
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < cycles; i++) begin
         rand_inputs(1'b0);
         #1;
         check_zero();
         @(posedge clk);
         #1;
         check_zero();
      end
      reset = 1'b1;
      stall = '0; flush = '0; alu_flags = 4'b0;
      nop();
   endtask

   function automatic logic [PW-1:0] pay_at(input int k);
      logic [NS*PW-1:0] tmp;
      tmp = payload_q;
      return tmp[k*PW +: PW];
   endfunction

   initial begin
      reset = 1'b0;
      stall = '0; flush = '0; alu_flags = 4'b0;
      nop();
      @(posedge clk); #1;
      reset_phase(4);

      // Reset release and first-instruction latency.
      set_dec(1, 0, 1, 0, 0, 2'b00, 4'he, 8'h11);
      step();
      check("t1_regw_s2_early", regw_q[1], 0);
      nop();
      step();
      check("t1_regw_s2", regw_q[1], 1);

      // Condition gating with Z set.
      set_dec(1, 0, 0, 0, 0, 2'b11, 4'he, 8'h20);
      alu_flags = 4'b0100;
      step();
      set_dec(1, 0, 1, 0, 0, 2'b00, 4'h0, 8'h21);
      step();
      set_dec(1, 0, 1, 0, 0, 2'b00, 4'h1, 8'h22);
      step();
      check("t2_eq_regw", regw_q[1], 1);
      check("t2_eq_valid", valid_q[1], 1);
      nop();
      step();
      check("t2_ne_regw", regw_q[1], 0);
      check("t2_ne_valid", valid_q[1], 1);

      // Held instruction writes flags once, on release.
      set_dec(1, 0, 0, 0, 0, 2'b11, 4'he, 8'h30);
      alu_flags = 4'b0000;
      step();
      set_dec(1, 0, 0, 0, 0, 2'b11, 4'he, 8'h31);
      step();
      nop();
      stall[0] = 1'b1;
      alu_flags = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_flags_held", flags, 4'b0000);
      end
      stall[0] = 1'b0;
      step();
      check("t3_flags_release", flags, 4'b1001);

      // Partial NZ-only update.
      set_dec(1, 0, 0, 0, 0, 2'b11, 4'he, 8'h40);
      alu_flags = 4'b0110;
      step();
      set_dec(1, 0, 0, 0, 0, 2'b10, 4'he, 8'h41);
      step();
      nop();
      alu_flags = 4'b1001;
      step();
      check("t4_flags_partial", flags, 4'b1010);

      // Stage-2 stall: hold stages 1-2, bubble into stage 3.
      for (int i = 0; i < 3; i++) begin
         set_dec(1, 0, 1, 0, 0, 2'b00, 4'he, 8'(8'ha1 + i));
         step();
      end
      set_dec(1, 0, 1, 0, 0, 2'b00, 4'he, 8'ha4);
      stall[1] = 1'b1;
      #1;
      check("t5_stall_d_o", stall_d_o, 1);
      step();
      check("t5_bubble_s3", valid_q[2], 0);
      check("t5_hold_s2", pay_at(1), 8'ha2);
      stall[1] = 1'b0;
      step();
      check("t5_s3_b", pay_at(2), 8'ha2);
      nop();
      step();
      check("t5_s3_c", pay_at(2), 8'ha3);
      step();
      check("t5_s3_d", pay_at(2), 8'ha4);

      // Flush beats stall on a branch in stage 1.
      set_dec(1, 0, 0, 0, 1, 2'b11, 4'he, 8'h60);
      alu_flags = 4'b0101;
      step();
      nop();
      flush[0] = 1'b1;
      stall[0] = 1'b1;
      #1;
      check("t6_branch_before", branch_taken_e, 1);
      step();
      flush[0] = 1'b0;
      stall[0] = 1'b0;
      #1;
      check("t6_branch_after", branch_taken_e, 0);
      check("t6_valid_s1", valid_q[0], 0);
      check("t6_flags", flags, 4'b1010);

      // Randomized traffic with a mid-run asynchronous reset.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) reset_phase(3);
         rand_inputs(1'b1);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cond_pipe_ctrl.md
Name: cond_pipe_ctrl

Overview:
Parametrised control-signal pipeline for the pipelined ARM core.
- Carries decoded control bits and a pass-through payload from decode through NSTAGES registered stages (stage 1 = Execute, 2 = Memory, 3 = Writeback, ...).
- Evaluates the ARM condition field in Execute against an internal NZCV register, gates state-changing bits, and updates flags.
- Provides per-stage stall/flush with automatic bubble insertion, plus valid bits not carried by the previous generation.

Parameters:
NSTAGES, 3, number of pipeline registers after decode (min 2).
PAY_W, 8, width of un-gated pass-through payload per stage (ALU control, ALU src, mem-to-reg, ...).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
valid_d  input  1  decode stage holds a real instruction.
pcs_d  input  1  writes PC.
regw_d  input  1  register write.
memw_d  input  1  memory write.
branch_d  input  1  branch instruction.
flagw_d  input  2  [1] update NZ, [0] update CV.
cond_d  input  4  instruction condition field [31:28].
payload_d  input  PAY_W  pass-through bits.
alu_flags  input  4  NZCV from ALU (Execute, combinational).
stall  input  NSTAGES  stall[k] holds stage k+1.
flush  input  NSTAGES  flush[k] clears stage k+1.
stall_d_o  output  1  decode must hold (effective stall of stage 1).
cond_ex_e  output  1  Execute condition passed and stage-1 valid.
branch_taken_e  output  1  stage-1 branch & cond_ex_e.
flags  output  4  architectural NZCV register.
valid_q  output  NSTAGES  per-stage valid.
pcs_q, regw_q, memw_q  output  NSTAGES each  per-stage control; stage 1 ungated, stages >=2 gated.
payload_q  output  NSTAGES*PAY_W  stage k+1 at [k*PAY_W +: PAY_W].

Behaviour:
- Reset (reset=0, async): all stage registers, valid_q, flags = 0. All outputs are 0 while reset is low. Asserting reset mid-operation discards all in-flight instructions.
- Effective stall: se[k] = OR of stall[k..NSTAGES-1]. A later-stage stall holds all earlier stages. stall_d_o = se[0].
- Stage 1 update, per clock:
  - flush[0] clears to 0.
  - else if se[0], hold.
  - else load the decode inputs. A load with valid_d=0 loads all-zero control.
- Stage k>=2 update, per clock:
  - flush[k-1] clears.
  - else if se[k-1], hold.
  - else if se[k-2], load a bubble (all zero).
  - else load from stage k-1.
  - Flush has priority over stall.
- Gating on the stage 1 -> 2 transfer:
  - regw, pcs and memw are ANDed with cond_ex_e.
  - valid and payload pass unchanged.
  - Stages >=3 copy without gating.
- Condition evaluation is combinational in stage 1 and uses the current flags register, i.e. the value before this cycle's update. Codes:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 4'b1111 = 0.
  - cond_ex_e = valid_q[0] & condition.
- Flags write: happens on the clock edge where stage 2 loads from stage 1 (not se[0]-bubble, not flush[1]), stage 1 is valid, cond_ex_e=1, and flagw != 0.
  - flagw[1] writes flags[3:2] <= alu_flags[3:2].
  - flagw[0] writes flags[1:0] <= alu_flags[1:0].
- An instruction held in stage 1 over multiple cycles writes flags exactly once.
- branch_taken_e is combinational. It is not gated by stall; the consumer combines it with hazard logic.
- Latency: decode -> stage k visible k cycles after load, absent stalls.
- NSTAGES < 2 is an elaboration error.

Decomposition:
- Shared package arm_pipe_pkg: condition-code constants (COND_EQ ... COND_AL, COND_NV), flag bit indices (N=3, Z=2, C=1, V=0), FLAGW_NZ/FLAGW_CV masks.
- Sub-module cond_eval (combinational cond + NZCV -> pass).
- Stage registers are generated with a for-generate loop; no separate register module.

Test Plan:
1. Reset: hold reset=0 with random inputs -> all outputs 0. Release, issue valid AL regw=1 -> regw_q[1]=1 exactly two cycles after load.
2. Condition gating: flags=0100 (Z), issue EQ regw=1 then NE regw=1 -> stage 2 regw = 1 then 0; valid_q[1]=1 for both.
3. Flags write once: stall[0]=1 for 3 cycles with a valid AL flagw=2'b11 instruction in stage 1, alu_flags=1001 -> flags stays 0000 until release, then flags=1001.
4. Partial update: flags=0110, flagw=2'b10, alu_flags=1001 -> flags=1010.
5. Bubble and stall propagation: stall[1]=1 for one cycle -> stall_d_o=1, stages 1-2 hold, stage 3 gets valid=0, then normal flow resumes with no duplicated or lost instruction.
6. Flush priority: flush[0]=1 together with stall[0]=1, branch in stage 1 -> stage 1 cleared next cycle, branch_taken_e=0, flags unchanged.
